// File: rtl/pc_pkg.sv
// Shared types and default sizes for the PC / return-address-stack unit.
// Imported by pc_stack_unit and ras_stack.
package pc_pkg;

   localparam int ADDR_W_DEF    = 9;
   localparam int RAS_DEPTH_DEF = 4;
   localparam int OFF_W_DEF     = 6;

   typedef enum logic [2:0] {
      START,
      STALL,
      RET,
      CALL,
      BRANCH,
      INCR
   } pc_action_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push onto a full stack overwrites
// the oldest entry and the count saturates at DEPTH.
module ras_stack #(
   parameter int DEPTH = 4,
   parameter int W     = 9,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  push_data,
   output logic [W-1:0]  top,
   output logic [CW-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wp;
   logic [PW-1:0] wp_inc;
   logic [PW-1:0] wp_dec;

   // Wrap the write pointer explicitly so non-power-of-two depths work.
   always_comb begin
      wp_inc = (wp == LAST) ? '0 : wp + 1'b1;
      wp_dec = (wp == '0) ? LAST : wp - 1'b1;
      top    = mem[wp_dec];
   end

   // Pointer, occupancy and entry storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp    <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         wp    <= '0;
         count <= '0;
      end else if (push) begin
         mem[wp] <= push_data;
         wp      <= wp_inc;
         if (count != FULL) count <= count + 1'b1;
      end else if (pop && count != '0) begin
         wp    <= wp_dec;
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with branch/call/return and a circular return stack.
// Define PC_STACK_CHK_EN to add the sticky ras_err overflow/underflow flag.
module pc_stack_unit
   import pc_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int RAS_DEPTH = RAS_DEPTH_DEF,
   parameter int OFF_W     = OFF_W_DEF
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [ADDR_W-1:0]              start_addr,
   input  logic                           stall,
   input  logic                           branch,
   input  logic                           taken,
   input  logic                           rel,
   input  logic [ADDR_W-1:0]              abs_target,
   input  logic [OFF_W-1:0]               offset,
   input  logic                           call,
   input  logic                           ret,
   output logic [ADDR_W-1:0]              pc_out,
   output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
   output logic                           ras_empty,
   output logic                           ras_full
`ifdef PC_STACK_CHK_EN
   ,
   output logic                           ras_err
`endif
);

   localparam int CW = $clog2(RAS_DEPTH + 1);

   pc_action_e        act;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] pc_rel;
   logic [ADDR_W-1:0] pc_next;
   logic [ADDR_W-1:0] ras_top;
   logic              push;
   logic              pop;

   assign ras_empty = (ras_count == '0);
   assign ras_full  = (ras_count == CW'(RAS_DEPTH));

   // Pick the single winning action and the next PC.
   always_comb begin
      act     = INCR;
      pc_inc  = pc_out + 1'b1;
      pc_rel  = pc_out +
                {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};
      pc_next = pc_inc;
      if (start)                act = START;
      else if (stall)           act = STALL;
      else if (ret)             act = RET;
      else if (call)            act = CALL;
      else if (branch && taken) act = BRANCH;
      unique case (act)
         START:   pc_next = start_addr;
         STALL:   pc_next = pc_out;
         RET:     pc_next = ras_empty ? pc_inc : ras_top;
         CALL:    pc_next = abs_target;
         BRANCH:  pc_next = rel ? pc_rel : abs_target;
         default: pc_next = pc_inc;
      endcase
      push = (act == CALL);
      pop  = (act == RET);
   end

   // Registered program counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_out <= '0;
      else        pc_out <= pc_next;
   end

   ras_stack #(
      .DEPTH (RAS_DEPTH),
      .W     (ADDR_W),
      .CW    (CW)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (act == START),
      .push      (push),
      .pop       (pop),
      .push_data (pc_inc),
      .top       (ras_top),
      .count     (ras_count)
   );

`ifdef PC_STACK_CHK_EN
   // Sticky error on pushing into a full stack or popping an empty one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ras_err <= 1'b0;
      else if (act == START)
         ras_err <= 1'b0;
      else if ((push && ras_full) || (pop && ras_empty))
         ras_err <= 1'b1;
   end
`endif

endmodule
